// File: rtl/uart_packer_pkg.sv
// Shared UART framing constants, used by the packer and the receive-side unpacker.
package uart_packer_pkg;

  localparam logic [7:0]  HDR_BASE = 8'h3F;
  localparam int unsigned TAG_W    = 2;
  localparam int unsigned CHUNK_W  = 6;
  localparam int unsigned HDR_CH_W = 3;

  // Number of payload bytes needed to carry a data_w-bit word.
  function automatic int unsigned payload_bytes(input int unsigned data_w);
    return (data_w + CHUNK_W - 1) / CHUNK_W;
  endfunction

endpackage

// File: rtl/uart_packer.sv
// Packs one DATA_W-bit word plus channel id into a header byte followed by
// tagged 6-bit payload bytes, handing them one at a time to a UART transmitter.
module uart_packer
  import uart_packer_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic [((CH_W > 0) ? CH_W : 1)-1:0] in_ch,
  output logic [7:0]                        tx_data,
  output logic                              tx_start,
  input  logic                              tx_done,
  output logic                              busy,
  output logic                              pkt_done
);

  localparam int unsigned     NB       = payload_bytes(DATA_W);
  localparam int unsigned     FIELD_W  = CHUNK_W * NB;
  localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NB);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t              state_q, state_d;
  logic [TAG_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q;
  logic [HDR_CH_W-1:0] ch_q, ch_in;
  logic                accept, done_d, pkt_done_q;
  logic [FIELD_W-1:0]  field;
  logic [CHUNK_W-1:0]  chunk;
  logic [7:0]          byte_sel;

  // Channel id narrowed/zero-extended to the header's 3-bit field.
  always_comb begin
    ch_in = '0;
    if (CH_W > 0) ch_in = HDR_CH_W'(in_ch);
  end

  // Left-align the latched word in the chunk field, zero padding in the LSBs.
  always_comb begin
    field = '0;
    field[FIELD_W-1 -: DATA_W] = data_q;
  end

  // Chunk k (1-based) is taken MSB-first from the aligned field.
  always_comb begin
    chunk = '0;
    for (int unsigned k = 1; k <= NB; k++) begin
      if (idx_q == TAG_W'(k)) chunk = field[FIELD_W-1-CHUNK_W*(k-1) -: CHUNK_W];
    end
  end

  // Byte mux on the index: header at 0, tagged payload bytes after.
  always_comb begin
    if (idx_q == '0) byte_sel = HDR_BASE ^ {{(8-HDR_CH_W){1'b0}}, ch_q};
    else             byte_sel = {idx_q, chunk};
  end

  // Next-state logic for the packet sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (tx_done) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d   = idx_q + TAG_W'(1);
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, index, and latched packet contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      data_q     <= '0;
      ch_q       <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pkt_done_q <= done_d;
      if (accept) begin
        data_q <= in_data;
        ch_q   <= ch_in;
      end
    end
  end

  // Outputs are gated by rst so they show reset values for the whole time rst is high.
  always_comb begin
    in_ready = (state_q == IDLE) && !rst;
    busy     = (state_q != IDLE) && !rst;
    tx_start = (state_q == SEND) && !rst;
    pkt_done = pkt_done_q && !rst;
    tx_data  = (rst || state_q == IDLE) ? 8'h00 : byte_sel;
  end

endmodule

// File: tb/tb_uart_packer.sv
// Bench for uart_packer: three instances (16b/3ch, 18b/3ch, 6b/single channel),
// a packet-level reference model, and a transmitter that acknowledges tx_start.
module tb_uart_packer;

  logic clk;
  logic rst;
  logic [2:0]       in_valid, in_ready, tx_start, tx_done, busy, pkt_done;
  logic [2:0][17:0] in_data;
  logic [2:0][2:0]  in_ch;
  logic [2:0][7:0]  tx_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_packer #(.DATA_W(16), .CH_W(3)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0][15:0]), .in_ch(in_ch[0]), .tx_data(tx_data[0]),
    .tx_start(tx_start[0]), .tx_done(tx_done[0]), .busy(busy[0]), .pkt_done(pkt_done[0]));

  uart_packer #(.DATA_W(18), .CH_W(3)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_ch(in_ch[1]), .tx_data(tx_data[1]),
    .tx_start(tx_start[1]), .tx_done(tx_done[1]), .busy(busy[1]), .pkt_done(pkt_done[1]));

  uart_packer #(.DATA_W(6), .CH_W(0)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2][5:0]), .in_ch(in_ch[2][0:0]), .tx_data(tx_data[2]),
    .tx_start(tx_start[2]), .tx_done(tx_done[2]), .busy(busy[2]), .pkt_done(pkt_done[2]));

  int unsigned vectors, errs;
  int          cyc_n, pd_cyc, acc_cyc, pd_cnt;
  logic [7:0]  log_q[$];

  // Reference model state per lane.
  logic [7:0] m_bytes [3][4];
  int         m_len[3], m_sent[3], cnt[3], lat[3];
  bit         m_active[3], m_out[3], exp_start[3], exp_done[3], acc[3];
  bit         stray_start[3], idle_pulse[3];

  function automatic int dw(input int l);
    return (l == 0) ? 16 : (l == 1) ? 18 : 6;
  endfunction

  function automatic int cw(input int l);
    return (l == 2) ? 0 : 3;
  endfunction

  task automatic chk8(input string nm, input int l, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s lane%0d: got %02h, want %02h (cycle %0d)", nm, l, act, exp, cyc_n);
    end
  endtask

  task automatic chk1(input string nm, input int l, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s lane%0d: got %0b, want %0b (cycle %0d)", nm, l, act, exp, cyc_n);
    end
  endtask

  task automatic timeout(input string nm);
    vectors++;
    errs++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc_n);
  endtask

  // Packet contents straight from the framing rules: header, then 6-bit chunks MSB-first.
  task automatic build(input int l);
    int nb, d, chm;
    longint unsigned val;
    d   = dw(l);
    nb  = (d + 5) / 6;
    val = (64'(in_data[l]) & ((64'd1 << d) - 64'd1)) << (6 * nb - d);
    chm = int'(in_ch[l]) & ((1 << cw(l)) - 1) & 7;
    m_bytes[l][0] = 8'h3F ^ 8'(chm);
    for (int k = 1; k <= nb; k++)
      m_bytes[l][k] = 8'((64'(k % 4) << 6) | ((val >> (6 * (nb - k))) & 64'd63));
    m_len[l]  = nb + 1;
    m_sent[l] = 0;
  endtask

  task automatic model_update();
    bit ns, nd;
    for (int l = 0; l < 3; l++) begin
      acc[l] = 1'b0;
      if (rst) begin
        m_active[l] = 1'b0; m_out[l] = 1'b0; exp_start[l] = 1'b0; exp_done[l] = 1'b0;
      end else begin
        ns = 1'b0; nd = 1'b0;
        if (!m_active[l]) begin
          if (in_valid[l]) begin
            build(l);
            m_active[l] = 1'b1; acc[l] = 1'b1; ns = 1'b1; acc_cyc = cyc_n;
          end
        end else if (m_out[l] && tx_done[l]) begin
          m_out[l] = 1'b0;
          m_sent[l]++;
          if (m_sent[l] == m_len[l]) begin m_active[l] = 1'b0; nd = 1'b1; end
          else ns = 1'b1;
        end
        if (exp_start[l]) m_out[l] = 1'b1;
        exp_start[l] = ns;
        exp_done[l]  = nd;
      end
    end
  endtask

  task automatic compare();
    for (int l = 0; l < 3; l++) begin
      chk1("in_ready", l, in_ready[l], !m_active[l] && !rst);
      chk1("busy", l, busy[l], m_active[l]);
      chk1("tx_start", l, tx_start[l], exp_start[l]);
      chk1("pkt_done", l, pkt_done[l], exp_done[l]);
      if (rst) chk8("tx_data_rst", l, tx_data[l], 8'h00);
      else if (m_active[l]) chk8("tx_data", l, tx_data[l], m_bytes[l][m_sent[l]]);
      if (tx_start[l]) log_q.push_back(tx_data[l]);
      if (pkt_done[l]) begin pd_cnt++; pd_cyc = cyc_n; end
    end
  endtask

  // Transmitter: acknowledges lat cycles after each tx_start, plus injected strays.
  task automatic responder();
    bit td;
    for (int l = 0; l < 3; l++) begin
      if (rst) begin
        cnt[l] = 0; tx_done[l] = 1'b0; idle_pulse[l] = 1'b0;
      end else begin
        td = 1'b0;
        if (tx_start[l]) begin cnt[l] = lat[l]; td = stray_start[l]; end
        else if (cnt[l] > 0) begin cnt[l]--; td = (cnt[l] == 0); end
        if (idle_pulse[l]) begin td = 1'b1; idle_pulse[l] = 1'b0; end
        tx_done[l] = td;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    cyc_n++;
    model_update();
    #1;
    compare();
    @(negedge clk);
    responder();
  endtask

  task automatic wait_acc(input int l);
    for (int i = 0; i < 400; i++) begin
      cyc();
      if (acc[l]) return;
    end
    timeout("accept");
  endtask

  task automatic wait_idle(input int l);
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (!m_active[l] && !in_valid[l]) begin
        repeat (3) cyc();
        return;
      end
    end
    timeout("packet_end");
  endtask

  task automatic wait_bytes(input int n);
    for (int i = 0; i < 400; i++) begin
      if (log_q.size() >= n) return;
      cyc();
    end
    timeout("byte_count");
  endtask

  task automatic send(input int l, input logic [17:0] d, input logic [2:0] ch);
    in_data[l]  = d;
    in_ch[l]    = ch;
    in_valid[l] = 1'b1;
    wait_acc(l);
    in_valid[l] = 1'b0;
    wait_idle(l);
  endtask

  task automatic clear_log();
    log_q.delete();
    pd_cnt = 0;
  endtask

  // Literal byte sequence e (first byte in the most significant used byte), n bytes.
  task automatic check_log(input string nm, input int l, input logic [63:0] e, input int n, input int npd);
    logic [7:0] act;
    chk8({nm, "_len"}, l, 8'(log_q.size()), 8'(n));
    for (int i = 0; i < n; i++) begin
      act = (i < int'(log_q.size())) ? log_q[i] : 8'h00;
      chk8($sformatf("%s_byte%0d", nm, i), l, act, e[8*(n-1-i) +: 8]);
    end
    chk8({nm, "_pkt_done_cnt"}, l, 8'(pd_cnt), 8'(npd));
  endtask

  initial begin
    vectors = 0; errs = 0; cyc_n = 0; pd_cyc = 0; acc_cyc = 0; pd_cnt = 0;
    rst = 1'b1;
    in_valid = '0; in_data = '0; in_ch = '0; tx_done = '0;
    for (int l = 0; l < 3; l++) begin
      m_active[l] = 1'b0; m_out[l] = 1'b0; exp_start[l] = 1'b0; exp_done[l] = 1'b0;
      acc[l] = 1'b0; m_len[l] = 0; m_sent[l] = 0; cnt[l] = 0; lat[l] = 10;
      stray_start[l] = 1'b0; idle_pulse[l] = 1'b0;
      for (int k = 0; k < 4; k++) m_bytes[l][k] = 8'h00;
    end

    // Reset state.
    repeat (3) cyc();
    chk1("reset_in_ready", 0, in_ready[0], 1'b0);
    chk8("reset_tx_data", 0, tx_data[0], 8'h00);
    rst = 1'b0;
    cyc();
    chk1("ready_after_reset", 0, in_ready[0], 1'b1);

    // 16-bit word, channel 0, slow transmitter.
    clear_log(); lat[0] = 10;
    send(0, 18'h0ABCD, 3'd0);
    check_log("w16_abcd", 0, 64'h3F6ABCF4, 4, 1);

    // 18-bit all-ones, channel 5.
    clear_log(); lat[1] = 3;
    send(1, 18'h3FFFF, 3'd5);
    check_log("w18_ones", 1, 64'h3A7FBFFF, 4, 1);

    // 6-bit single-channel packer, fastest transmitter.
    clear_log(); lat[2] = 1;
    send(2, 18'h0002A, 3'd7);
    check_log("w6", 2, 64'h3F6A, 2, 1);

    // Back-to-back: in_valid held, in_data changed while the first packet is in flight.
    clear_log(); lat[0] = 4;
    in_data[0] = 18'h01234; in_ch[0] = 3'd2; in_valid[0] = 1'b1;
    wait_acc(0);
    in_data[0] = 18'h05678; in_ch[0] = 3'd1;
    wait_acc(0);
    chk8("b2b_accept_in_pkt_done_cycle", 0, 8'(acc_cyc - pd_cyc), 8'd1);
    in_valid[0] = 1'b0;
    wait_idle(0);
    check_log("b2b", 0, 64'h3D44A3D03E55A7E0, 8, 2);

    // Stray tx_done in IDLE and coincident with every tx_start.
    clear_log(); lat[0] = 2; stray_start[0] = 1'b1;
    idle_pulse[0] = 1'b1;
    repeat (3) cyc();
    chk1("idle_tx_done_ignored", 0, busy[0], 1'b0);
    send(0, 18'h0BEEF, 3'd3);
    stray_start[0] = 1'b0;
    check_log("stray", 0, 64'h3C6FAEFC, 4, 1);

    // Reset while waiting on byte 2, then a clean packet.
    clear_log(); lat[0] = 10;
    in_data[0] = 18'h0ABCD; in_ch[0] = 3'd0; in_valid[0] = 1'b1;
    wait_acc(0);
    in_valid[0] = 1'b0;
    wait_bytes(3);
    repeat (4) cyc();
    rst = 1'b1;
    repeat (2) cyc();
    chk1("mid_rst_busy", 0, busy[0], 1'b0);
    rst = 1'b0;
    cyc();
    chk1("ready_after_mid_rst", 0, in_ready[0], 1'b1);
    repeat (20) cyc();
    chk8("no_start_after_rst", 0, 8'(log_q.size()), 8'd3);
    send(0, 18'h00001, 3'd4);
    check_log("after_rst", 0, 64'h3F6ABC3B4080C4, 7, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
